ifid_buffer: RTL and testbench
==============================

Name: ifid_buffer

Overview:
- Two-entry instruction buffer between the instruction fetch stage and decode.
- Accepts a fetched 16-bit instruction and its PC through a valid/ready handshake, then queues it in order.
- Splits the head entry into opcode, rd, rs and imm fields; imm drives the 4-bit input of the sign extender directly.
- Absorbs decode stalls and discards queued instructions on a branch flush.

Parameters:
- INSTR_WIDTH, 16, instruction word width; fields are opcode[15:12], rd[11:8], rs[7:4], imm[3:0].
- PC_WIDTH, 16, width of the program-counter tag stored with each instruction.
- IMM_WIDTH, 4, immediate field width; must match the sign extender input width.
- DEPTH, 2, number of buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_instr  in  INSTR_WIDTH  fetched instruction word.
- in_pc  in  PC_WIDTH  address of in_instr.
- in_ready  out  1  buffer can accept an instruction this cycle.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry this cycle.
- out_opcode  out  4  head instr[15:12].
- out_rd  out  4  head instr[11:8].
- out_rs  out  4  head instr[7:4].
- out_imm  out  IMM_WIDTH  head instr[IMM_WIDTH-1:0]; connects to the sign extender input.
- out_pc  out  PC_WIDTH  PC tag of the head entry.
- flush  in  1  discard all queued entries (taken branch).
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset is sampled only at the posedge of clk, when reset==0.
  - Read pointer, write pointer and count go to 0.
  - out_valid=0 and in_ready=0 while reset is asserted.
  - Storage contents are don't-care.
- in_ready = reset && (count < DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- Push: occurs when in_valid && in_ready. {in_instr, in_pc} is written at the write pointer, and the pointer increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. The read pointer increments modulo DEPTH.
- Count: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N with out_valid=1. Minimum in-to-out latency is 1 cycle. There is no same-cycle bypass.
- out_valid = (count != 0).
- Output fields:
  - When out_valid=1, out_opcode, out_rd, out_rs, out_imm and out_pc come combinationally from the entry at the read pointer.
  - When out_valid=0, all field outputs are driven to 0.
- Full (count==DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A pop in this cycle raises in_ready on the next cycle, not this one.
- Empty (count==0):
  - out_ready is ignored; no pop occurs and the read pointer does not move.
  - A push this cycle gives out_valid=1 next cycle.
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Order is strictly FIFO across the wrap.
- Flush (flush==1 at an edge, reset==1):
  - Pointers and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - Flush has priority over push and pop.
  - out_valid=0 after the edge.
- Reset has priority over flush.
- Reset mid-operation: all queued entries are lost. The first post-reset push lands in entry 0.
- Handshake rules:
  - Upstream must hold in_instr and in_pc stable while in_valid=1 and in_ready=0.
  - The head entry and all field outputs stay stable while out_valid=1 and out_ready=0.
- No arithmetic on data. imm is passed raw; sign extension is done downstream.

Test Plan:
- Single pass-through:
  - Stimulus: reset, then push in_instr=16'h3A5A with in_pc=16'h0010, out_ready=1.
  - Response: next cycle out_valid=1, opcode=3, rd=A, rs=5, imm=A, pc=0010; the downstream sign extender gives 16'hFFFA.
  - Response: the following cycle out_valid=0 and all fields are 0.
- Fill and stall:
  - Stimulus: out_ready=0; push 16'h1234 at PC 0x0000, then 16'h5678 at PC 0x0002.
  - Response: count=2 and in_ready=0; a third push of 16'h9ABC is not accepted.
  - Response: the head holds opcode=1 and imm=4 stable.
  - Stimulus: set out_ready=1.
  - Response: outputs 1234, 5678, then 9ABC in order.
- Simultaneous push and pop at count=1:
  - Stimulus: push 16'hF00F while popping the head.
  - Response: count stays 1 and the next head is F00F.
  - Stimulus: keep streaming 6 instructions back-to-back.
  - Response: pointers wrap and the 6 instructions come out in order with no bubbles.
- Flush:
  - Stimulus: with count=2, assert flush together with in_valid (16'hAAAA).
  - Response: next cycle count=0 and out_valid=0; AAAA is never output.
  - Stimulus: push 16'h0BBB.
  - Response: next cycle out_valid=1 with imm=B, pc=the pushed PC.
- Reset mid-operation:
  - Stimulus: with count=2, drive reset=0 for one edge.
  - Response: out_valid=0, count=0, and in_ready=0 during reset.
  - Response: after reset returns to 1, in_ready=1 and the old entries never reappear.
- Empty pop:
  - Stimulus: out_ready=1 for 3 cycles with no pushes.
  - Response: count stays 0, no underflow, and the first later push appears correctly.

Source files
------------

// File: rtl/ifid_buffer.sv
// Two-entry in-order instruction buffer between fetch and decode.
// Splits the head instruction into opcode/rd/rs/imm fields for the decoder and sign extender.
module ifid_buffer #(
   parameter int INSTR_WIDTH = 16,
   parameter int PC_WIDTH    = 16,
   parameter int IMM_WIDTH   = 4,
   parameter int DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [INSTR_WIDTH-1:0]     in_instr,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_opcode,
   output logic [3:0]                 out_rd,
   output logic [3:0]                 out_rs,
   output logic [IMM_WIDTH-1:0]       out_imm,
   output logic [PC_WIDTH-1:0]        out_pc,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   push;
   logic                   pop;
   logic                   head_valid;
   logic [INSTR_WIDTH-1:0] head_instr;
   logic [PC_WIDTH-1:0]    head_pc;
   logic [INSTR_WIDTH-1:0] entry_instr [DEPTH];
   logic [PC_WIDTH-1:0]    entry_pc    [DEPTH];

   // Handshake flags depend on registered state only; out_ready never reaches in_ready.
   assign in_ready   = reset && (count_q < FULL_CNT);
   assign head_valid = reset && (count_q != '0);
   assign push       = in_valid && in_ready;
   assign pop        = head_valid && out_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is not reset; occupancy alone decides what is visible.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic                   wr_en;
         logic [INSTR_WIDTH-1:0] instr_q;
         logic [PC_WIDTH-1:0]    pc_q;

         assign wr_en = push && !flush && (wr_ptr_q == PTR_W'(gi));

         always_ff @(posedge clk) begin
            if (wr_en) begin
               instr_q <= in_instr;
               pc_q    <= in_pc;
            end
         end

         assign entry_instr[gi] = instr_q;
         assign entry_pc[gi]    = pc_q;
      end
   endgenerate

   assign head_instr = entry_instr[rd_ptr_q];
   assign head_pc    = entry_pc[rd_ptr_q];

   assign out_valid  = head_valid;
   assign out_opcode = head_valid ? head_instr[INSTR_WIDTH-1 -: 4] : '0;
   assign out_rd     = head_valid ? head_instr[INSTR_WIDTH-5 -: 4] : '0;
   assign out_rs     = head_valid ? head_instr[INSTR_WIDTH-9 -: 4] : '0;
   assign out_imm    = head_valid ? head_instr[IMM_WIDTH-1:0]     : '0;
   assign out_pc     = head_valid ? head_pc                       : '0;
   assign count      = count_q;

endmodule

// File: tb/tb_ifid_buffer.sv
// Directed self-checking bench for ifid_buffer: pass-through, stall, streaming, flush, reset, empty pop.
module tb_ifid_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_opcode;
   logic [3:0]  out_rd;
   logic [3:0]  out_rs;
   logic [3:0]  out_imm;
   logic [15:0] out_pc;
   logic        flush;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   logic [15:0] head;
   logic [15:0] sext;
   assign head = {out_opcode, out_rd, out_rs, out_imm};
   assign sext = {{12{out_imm[3]}}, out_imm};

   ifid_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_rs     (out_rs),
      .out_imm    (out_imm),
      .out_pc     (out_pc),
      .flush      (flush),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if ({head, out_pc} !== 32'h0) begin errors++; $display("FAIL reset_fields got %h exp 0", {head, out_pc}); end
      reset = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_pass_through();
      in_valid = 1'b1; in_instr = 16'h3A5A; in_pc = 16'h0010; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_valid got %b exp 1", out_valid); end
      checks++; if ({out_opcode, out_rd, out_rs, out_imm} !== {4'h3, 4'hA, 4'h5, 4'hA}) begin errors++; $display("FAIL pt_fields got %h exp 3a5a", head); end
      checks++; if (out_pc !== 16'h0010) begin errors++; $display("FAIL pt_pc got %h exp 0010", out_pc); end
      checks++; if (sext !== 16'hFFFA) begin errors++; $display("FAIL pt_sext got %h exp fffa", sext); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL pt_count got %0d exp 1", count); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pt_drain_valid got %b exp 0", out_valid); end
      checks++; if ({head, out_pc} !== 32'h0) begin errors++; $display("FAIL pt_drain_fields got %h exp 0", {head, out_pc}); end
      $display("test_pass_through instr=3a5a pc=0010");
   endtask

   task automatic test_fill_stall();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 16'h1234; in_pc = 16'h0000;
      step();
      in_instr = 16'h5678; in_pc = 16'h0002;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d exp 2", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
      in_instr = 16'h9ABC; in_pc = 16'h0004;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", count); end
      checks++; if (head !== 16'h1234 || out_opcode !== 4'h1 || out_imm !== 4'h4) begin errors++; $display("FAIL stall_head got %h exp 1234", head); end
      checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL stall_pc got %h exp 0000", out_pc); end
      out_ready = 1'b1;
      step();
      // Pop at full does not open in_ready in the same cycle, so 9ABC is still waiting.
      checks++; if (head !== 16'h5678 || out_pc !== 16'h0002) begin errors++; $display("FAIL drain1 got %h/%h exp 5678/0002", head, out_pc); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL drain1_count got %0d exp 1", count); end
      step();
      in_valid = 1'b0;
      checks++; if (head !== 16'h9ABC || out_pc !== 16'h0004) begin errors++; $display("FAIL drain2 got %h/%h exp 9abc/0004", head, out_pc); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL drain2_count got %0d exp 1", count); end
      step();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain3 got count %0d valid %b exp 0 0", count, out_valid); end
      $display("test_fill_stall order 1234 5678 9abc");
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream [6];
      stream = '{16'h2001, 16'h3102, 16'h4203, 16'h5304, 16'h6405, 16'h7506};
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 16'h1111; in_pc = 16'h0100;
      step();
      checks++; if (count !== 2'd1 || head !== 16'h1111) begin errors++; $display("FAIL b2b_prime got %0d/%h exp 1/1111", count, head); end
      in_instr = 16'hF00F; in_pc = 16'h0102; out_ready = 1'b1;
      step();
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_pushpop_count got %0d exp 1", count); end
      checks++; if (head !== 16'hF00F || out_pc !== 16'h0102) begin errors++; $display("FAIL b2b_pushpop_head got %h/%h exp f00f/0102", head, out_pc); end
      for (int k = 0; k < 6; k++) begin
         in_instr = stream[k]; in_pc = 16'h0600 + 16'(2 * k);
         step();
         checks++;
         if (out_valid !== 1'b1 || count !== 2'd1 || head !== stream[k] || out_pc !== 16'h0600 + 16'(2 * k)) begin
            errors++;
            $display("FAIL b2b_stream%0d got v%b c%0d %h/%h exp v1 c1 %h/%h", k, out_valid, count, head, out_pc, stream[k], 16'h0600 + 16'(2 * k));
         end
         $display("stream %0d head=%h pc=%h", k, head, out_pc);
      end
      in_valid = 1'b0;
      step();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0d/%b exp 0/0", count, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 16'h2222; in_pc = 16'h0010;
      step();
      in_instr = 16'h3333; in_pc = 16'h0012;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got %0d exp 2", count); end
      flush = 1'b1; in_instr = 16'hAAAA; in_pc = 16'h0014; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_full got %0d/%b exp 0/0", count, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0 || head === 16'hAAAA) begin errors++; $display("FAIL flush_no_aaaa got %b/%h exp 0", out_valid, head); end
      in_valid = 1'b1; in_instr = 16'h0BBB; in_pc = 16'h0200;
      step();
      checks++; if (out_valid !== 1'b1 || out_imm !== 4'hB || head !== 16'h0BBB || out_pc !== 16'h0200) begin errors++; $display("FAIL flush_repush got %b %h/%h exp 1 0bbb/0200", out_valid, head, out_pc); end
      // Flush at count=1 with a live push: the push must be discarded too.
      flush = 1'b1; in_instr = 16'hCCCC; in_pc = 16'h0202;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_push got %0d/%b exp 0/0", count, out_valid); end
      step();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got %0d/%b exp 0/0", count, out_valid); end
      $display("test_flush done");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 16'h4444; in_pc = 16'h0300;
      step();
      in_instr = 16'h5555; in_pc = 16'h0302;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL rst_pre_count got %0d exp 2", count); end
      reset = 1'b0; in_instr = 16'hDDDD; in_pc = 16'h0304;
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_during got rdy %b val %b exp 0 0", in_ready, out_valid); end
      step();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_edge got c%0d v%b r%b exp 0 0 0", count, out_valid, in_ready); end
      reset = 1'b1; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_release got r%b v%b exp 1 0", in_ready, out_valid); end
      step();
      in_valid = 1'b1; in_instr = 16'h6666; in_pc = 16'h0400;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 2'd1 || head !== 16'h6666 || out_pc !== 16'h0400) begin errors++; $display("FAIL rst_repush got %0d %h/%h exp 1 6666/0400", count, head, out_pc); end
      out_ready = 1'b1;
      step();
      checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale got %0d/%b %h exp 0/0", count, out_valid, head); end
      $display("test_reset_mid done");
   endtask

   task automatic test_empty_pop();
      out_ready = 1'b1; in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop%0d got %0d/%b exp 0/0", k, count, out_valid); end
      end
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 16'h7A7A; in_pc = 16'h0500;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 2'd1 || head !== 16'h7A7A || out_pc !== 16'h0500) begin errors++; $display("FAIL empty_push got %0d %h/%h exp 1 7a7a/0500", count, head, out_pc); end
      in_valid = 1'b1; in_instr = 16'h8B8B; in_pc = 16'h0502;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (count !== 2'd2 || head !== 16'h7A7A) begin errors++; $display("FAIL empty_second got %0d %h exp 2 7a7a", count, head); end
      step();
      checks++; if (head !== 16'h8B8B || out_pc !== 16'h0502) begin errors++; $display("FAIL empty_order got %h/%h exp 8b8b/0502", head, out_pc); end
      step();
      $display("test_empty_pop done");
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill_stall();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_empty_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
